// File: rtl/div_by_3_pkg.sv
// Shared types and constants for the divide-by-3 clock tick generator.
package div_by_3_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

    localparam int unsigned DIV_RATIO = 3;

endpackage

// File: rtl/div_by_3.sv
// Divide-by-3 Moore FSM: y pulses high for one clock in every three.
module div_by_3
    import div_by_3_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic y
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // The unused 2'b11 encoding falls into the default arm and recovers to S0.
    always_comb begin
        next_state = S0;
        case (state)
            S0:      next_state = S1;
            S1:      next_state = S2;
            default: next_state = S0;
        endcase
    end

    assign y = (state == S0);

endmodule

// File: tb/tb_div_by_3.sv
// Scoreboard bench for div_by_3: a phase model pushes expected y per edge.
module tb_div_by_3;
    import div_by_3_pkg::*;

    logic clk;
    logic reset;
    logic y;

    int unsigned passed;
    int unsigned total;
    int unsigned phase;
    bit          exp_q[$];
    bit          exp;

    div_by_3 dut (
        .clk   (clk),
        .reset (reset),
        .y     (y)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Predict the next edge's output, then let that edge happen.
    task automatic advance();
        phase = (phase + 1) % DIV_RATIO;
        exp_q.push_back(phase == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        phase = 0;
        #1;
        total++;
        if (y !== 1'b1) $display("FAIL reset_initial: y=%b expected 1", y);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (y !== 1'b1) $display("FAIL reset_hold edge %0d: y=%b expected 1", i, y);
            else passed++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (y !== 1'b1) $display("FAIL reset_release: y=%b expected 1", y);
        else passed++;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 18; i++) begin
            advance();
            exp = exp_q.pop_front();
            total++;
            if (y !== exp) $display("FAIL free_run cycle %0d: y=%b expected %b", i, y, exp);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        // Step into S1, then S2, and hit reset between edges each time.
        for (int k = 1; k <= 2; k++) begin
            while (phase != k) begin
                advance();
                exp = exp_q.pop_front();
                total++;
                if (y !== exp) $display("FAIL async_pre phase %0d: y=%b expected %b", k, y, exp);
                else passed++;
            end
            @(negedge clk);
            reset = 1'b1;
            #1;
            total++;
            if (y !== 1'b1) $display("FAIL async_reset from S%0d: y=%b expected 1", k, y);
            else passed++;
            phase = 0;
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 3; i++) begin
                advance();
                exp = exp_q.pop_front();
                total++;
                if (y !== exp) $display("FAIL async_restart %0d: y=%b expected %b", i, y, exp);
                else passed++;
            end
        end
    endtask

    task automatic test_coincident_release();
        @(negedge clk);
        reset = 1'b1;
        phase = 0;
        @(posedge clk);
        reset <= 1'b0;
        #1;
        total++;
        if (y !== 1'b1) $display("FAIL coincident_edge: y=%b expected 1", y);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            advance();
            exp = exp_q.pop_front();
            total++;
            if (y !== exp) $display("FAIL coincident_after %0d: y=%b expected %b", i, y, exp);
            else passed++;
        end
    endtask

    task automatic test_illegal_state();
        @(negedge clk);
        force dut.state = state_t'(2'b11);
        #1;
        total++;
        if (y !== 1'b0) $display("FAIL illegal_decode: y=%b expected 0", y);
        else passed++;
        release dut.state;
        phase = DIV_RATIO - 1;
        for (int i = 0; i < 4; i++) begin
            advance();
            exp = exp_q.pop_front();
            total++;
            if (y !== exp) $display("FAIL illegal_recover %0d: y=%b expected %b", i, y, exp);
            else passed++;
        end
    endtask

    task automatic test_long_run();
        int unsigned highs;
        int unsigned doubles;
        int unsigned errs;
        logic prev;
        highs = 0;
        doubles = 0;
        errs = 0;
        prev = 1'b0;
        for (int i = 0; i < 300; i++) begin
            advance();
            exp = exp_q.pop_front();
            if (y !== exp) errs++;
            if (y === 1'b1) highs++;
            if (y === 1'b1 && prev === 1'b1) doubles++;
            prev = y;
        end
        total++;
        if (errs != 0) $display("FAIL long_run_sequence: errors=%0d expected 0", errs);
        else passed++;
        total++;
        if (highs != 100) $display("FAIL long_run_highs: count=%0d expected 100", highs);
        else passed++;
        total++;
        if (doubles != 0) $display("FAIL long_run_adjacent: count=%0d expected 0", doubles);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        phase = 0;
        reset = 1'b1;
        test_reset();
        test_free_run();
        test_async_reset();
        test_coincident_release();
        test_illegal_state();
        test_long_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
